// File: rtl/dp_tcdm_bridge_pkg.sv
// Shared types and defaults for the dot-product accelerator TCDM request bridge.
package dp_package;

  localparam int unsigned DP_TCDM_AW        = 32;
  localparam int unsigned DP_TCDM_DW        = 32;
  localparam int unsigned DP_TCDM_DEPTH     = 2;
  localparam int unsigned DP_TCDM_MAX_OUTST = 4;

  typedef struct packed {
    logic [DP_TCDM_AW-1:0]   add;
    logic                    wen;
    logic [DP_TCDM_DW/8-1:0] be;
    logic [DP_TCDM_DW-1:0]   data;
  } dp_tcdm_entry_t;

  // Idle bus value: everything zero, wen parked at "read".
  localparam dp_tcdm_entry_t DP_TCDM_ENTRY_RST = '{add: '0, wen: 1'b1, be: '0, data: '0};

endpackage

// File: rtl/dp_tcdm_bridge_fifo.sv
// Single-port request FIFO, DEPTH entries; head is valid the cycle after the push.
// Caller gates push on count < DEPTH and pop on count != 0; clear wins over both.
module dp_tcdm_fifo
  import dp_package::*;
#(
  parameter type         entry_t = dp_tcdm_entry_t,
  parameter entry_t      RST_VAL = DP_TCDM_ENTRY_RST,
  parameter int unsigned DEPTH   = DP_TCDM_DEPTH,
  localparam int unsigned CW     = $clog2(DEPTH + 1),
  localparam int unsigned PW     = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          clear_i,
  input  logic          push_i,
  input  entry_t        data_i,
  input  logic          pop_i,
  output entry_t        head_o,
  output logic [CW-1:0] cnt_o
);

  entry_t        mem_q [DEPTH];
  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          push_ok, pop_ok;

  assign push_ok = push_i && !clear_i && (cnt_q < CW'(DEPTH));
  assign pop_ok  = pop_i && !clear_i && (cnt_q != '0);

  // Pointers wrap by natural overflow (DEPTH is a power of two); fullness comes from cnt_q.
  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (clear_i) begin
      wptr_d = '0;
      rptr_d = '0;
      cnt_d  = '0;
    end else begin
      if (push_ok) wptr_d = wptr_q + 1'b1;
      if (pop_ok)  rptr_d = rptr_q + 1'b1;
      if (push_ok && !pop_ok)      cnt_d = cnt_q + 1'b1;
      else if (pop_ok && !push_ok) cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= RST_VAL;
    end else if (push_ok) begin
      mem_q[wptr_q] <= data_i;
    end
  end

  assign head_o = mem_q[rptr_q];
  assign cnt_o  = cnt_q;

endmodule

// File: rtl/dp_tcdm_bridge.sv
// Per-port TCDM request bridge: elastic FIFO, in-flight credit limit, synchronous flush.
// Request path 1 cycle, response path 0 cycles; in_gnt drops on full FIFO, exhausted credit or clear.
module dp_tcdm_bridge
  import dp_package::*;
#(
  parameter int unsigned N_PORTS   = 4,
  parameter int unsigned DEPTH     = DP_TCDM_DEPTH,
  parameter int unsigned MAX_OUTST = DP_TCDM_MAX_OUTST,
  parameter int unsigned AW        = DP_TCDM_AW,
  parameter int unsigned DW        = DP_TCDM_DW
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     clear_i,
  input  logic [N_PORTS-1:0]       in_req,
  output logic [N_PORTS-1:0]       in_gnt,
  input  logic [N_PORTS*AW-1:0]    in_add,
  input  logic [N_PORTS-1:0]       in_wen,
  input  logic [N_PORTS*DW/8-1:0]  in_be,
  input  logic [N_PORTS*DW-1:0]    in_data,
  output logic [N_PORTS*DW-1:0]    in_r_data,
  output logic [N_PORTS-1:0]       in_r_valid,
  output logic [N_PORTS-1:0]       out_req,
  input  logic [N_PORTS-1:0]       out_gnt,
  output logic [N_PORTS*AW-1:0]    out_add,
  output logic [N_PORTS-1:0]       out_wen,
  output logic [N_PORTS*DW/8-1:0]  out_be,
  output logic [N_PORTS*DW-1:0]    out_data,
  input  logic [N_PORTS*DW-1:0]    out_r_data,
  input  logic [N_PORTS-1:0]       out_r_valid,
  output logic [N_PORTS-1:0]       busy_o
);

  localparam int unsigned BW = DW / 8;
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned OW = $clog2(MAX_OUTST + 1);
  localparam int unsigned SW = ((CW > OW) ? CW : OW) + 1;

  typedef struct packed {
    logic [AW-1:0] add;
    logic          wen;
    logic [BW-1:0] be;
    logic [DW-1:0] data;
  } entry_t;

  localparam entry_t ENTRY_RST = '{add: '0, wen: 1'b1, be: '0, data: '0};

  // The interconnect answers each port in order, so responses need no buffering.
  assign in_r_data  = out_r_data;
  assign in_r_valid = out_r_valid;

  for (genvar p = 0; p < N_PORTS; p++) begin : g_port
    entry_t        push_dat;
    entry_t        head_dat;
    logic [CW-1:0] fifo_cnt;
    logic [OW-1:0] outst_q, outst_d;
    logic [SW-1:0] credit_used;
    logic          push, pop, rd_issue, rsp;

    assign push_dat = '{add:  in_add[p*AW +: AW],
                        wen:  in_wen[p],
                        be:   in_be[p*BW +: BW],
                        data: in_data[p*DW +: DW]};

    // Grant is a function of registered state and clear only, never of in_req.
    assign credit_used = SW'(fifo_cnt) + SW'(outst_q);
    assign in_gnt[p]   = !clear_i && (fifo_cnt < CW'(DEPTH)) && (credit_used < SW'(MAX_OUTST));

    assign push     = in_req[p] && in_gnt[p];
    assign out_req[p] = (fifo_cnt != '0);
    assign pop      = out_req[p] && out_gnt[p];
    assign rd_issue = pop && head_dat.wen;
    assign rsp      = out_r_valid[p];

    dp_tcdm_fifo #(
      .entry_t (entry_t),
      .RST_VAL (ENTRY_RST),
      .DEPTH   (DEPTH)
    ) i_fifo (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .clear_i (clear_i),
      .push_i  (push),
      .data_i  (push_dat),
      .pop_i   (pop),
      .head_o  (head_dat),
      .cnt_o   (fifo_cnt)
    );

    assign out_add[p*AW +: AW]  = head_dat.add;
    assign out_wen[p]           = head_dat.wen;
    assign out_be[p*BW +: BW]   = head_dat.be;
    assign out_data[p*DW +: DW] = head_dat.data;

    // Not touched by clear: reads already on the interconnect still come back.
    always_comb begin
      outst_d = outst_q;
      if (rd_issue && !rsp) begin
        outst_d = outst_q + 1'b1;
      end else if (rsp && !rd_issue && (outst_q != '0)) begin
        outst_d = outst_q - 1'b1;
      end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) outst_q <= '0;
      else         outst_q <= outst_d;
    end

    assign busy_o[p] = (fifo_cnt != '0) || (outst_q != '0);

    a_no_rsp_underflow : assert property (@(posedge clk_i) disable iff (!rst_ni)
      !(rsp && !rd_issue && (outst_q == '0)));
  end

endmodule
